// File: rtl/rsa_modexp_ct_if.sv
// Request/response bundle for the modular-exponentiation engine.
// The master side issues requests and the slave side is the engine.
interface rsa_modexp_ct_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic             const_time;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] exp;
  logic [WIDTH-1:0] modulus;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             error;
  logic [31:0]      cycles;

  modport master (
    output start, const_time, base, exp, modulus,
    input  result, busy, done, error, cycles
  );

  modport slave (
    input  start, const_time, base, exp, modulus,
    output result, busy, done, error, cycles
  );
endinterface

// File: rtl/rsa_modexp_ct.sv
// Left-to-right square-and-multiply engine with a bit-serial interleaved modular multiplier.
// An optional constant-time mode always runs the multiply step and discards unused products.
module rsa_modexp_ct #(
  parameter int unsigned WIDTH = 16
) (
  input logic             clk,
  input logic             rst,
  rsa_modexp_ct_if.slave  bus
);
  localparam int unsigned IdxW = $clog2(WIDTH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StSqr, StMul, StFin} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] base_q, exp_q, mod_q, r_q, result_q;
  logic [WIDTH+1:0] p_q;
  logic [IdxW-1:0]  i_q, j_q;
  logic             ct_q, err_q, error_q;
  logic [31:0]      cnt_q, cycles_q;

  logic             bad_op;
  logic [WIDTH+1:0] n_ext, p_dbl, p_sub, p_next;
  logic [WIDTH-1:0] mm_b;
  logic             mm_last, exp_bit;

  assign bad_op = (bus.modulus < WIDTH'(2)) || (bus.base >= bus.modulus);

  // One multiplier bit per cycle; the accumulator stays below n after the two reductions.
  always_comb begin
    n_ext   = {2'b00, mod_q};
    mm_b    = (state_q == StMul) ? base_q : r_q;
    p_dbl   = (p_q << 1) + (r_q[j_q] ? {2'b00, mm_b} : '0);
    p_sub   = (p_dbl >= n_ext) ? p_dbl - n_ext : p_dbl;
    p_next  = (p_sub >= n_ext) ? p_sub - n_ext : p_sub;
    mm_last = (j_q == '0);
    exp_bit = exp_q[i_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = bad_op ? StFin : StSqr;
      end
      StSqr: begin
        if (mm_last) begin
          if (ct_q || exp_bit)  state_d = StMul;
          else if (i_q == '0)   state_d = StFin;
          else                  state_d = StSqr;
        end
      end
      StMul: begin
        if (mm_last) state_d = (i_q == '0) ? StFin : StSqr;
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q   <= '0;
      exp_q    <= '0;
      mod_q    <= '0;
      r_q      <= '0;
      p_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      ct_q     <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
      cycles_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            base_q   <= bus.base;
            exp_q    <= bus.exp;
            mod_q    <= bus.modulus;
            ct_q     <= bus.const_time;
            err_q    <= bad_op;
            r_q      <= WIDTH'(1);
            p_q      <= '0;
            i_q      <= LastIdx;
            j_q      <= LastIdx;
            cnt_q    <= 32'd1;
            result_q <= '0;
            error_q  <= 1'b0;
          end
        end
        StSqr, StMul: begin
          cnt_q <= cnt_q + 32'd1;
          if (mm_last) begin
            p_q <= '0;
            j_q <= LastIdx;
            // A constant-time dummy multiply leaves R untouched.
            if (state_q == StSqr || exp_bit) r_q <= p_next[WIDTH-1:0];
            if (i_q != '0) begin
              if (state_q == StMul || !(ct_q || exp_bit)) i_q <= i_q - 1'b1;
            end
          end else begin
            p_q <= p_next;
            j_q <= j_q - 1'b1;
          end
        end
        StFin: begin
          result_q <= err_q ? '0 : r_q;
          error_q  <= err_q;
          cycles_q <= cnt_q;
        end
        default: ;
      endcase
    end
  end

  // The done cycle shows the fresh values before they are latched into the hold registers.
  always_comb begin
    bus.busy   = (state_q != StIdle);
    bus.done   = (state_q == StFin);
    bus.result = result_q;
    bus.error  = error_q;
    bus.cycles = cycles_q;
    if (state_q == StFin) begin
      bus.result = err_q ? '0 : r_q;
      bus.error  = err_q;
      bus.cycles = cnt_q;
    end
  end
endmodule

// File: doc/rsa_modexp_ct.md
# rsa_modexp_ct

Parametrised modular-exponentiation engine (result = base^exp mod modulus) for RSA encrypt/decrypt. It is the successor to the repeated-multiply decryptor: a left-to-right square-and-multiply with a built-in bit-serial modular multiplier, a full-width operand parameter, and a run-time constant-time mode that removes exponent-dependent latency. A latency counter is exported so the timing-side-channel bench can measure both modes directly.

## Interface
- WIDTH, 16, bit width of base, exp, modulus and result (≥ 4)
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only in a cycle where busy=0
- const_time  input  1  1 = always perform the multiply step; 0 = multiply only on exponent 1-bits
- base  input  WIDTH  message/ciphertext, must be < modulus
- exp  input  WIDTH  public or private exponent
- modulus  input  WIDTH  n, must be ≥ 2
- result  output  WIDTH  base^exp mod modulus, valid from done pulse until next accepted start
- busy  output  1  high from cycle after acceptance through the done cycle
- done  output  1  one-cycle completion pulse
- error  output  1  operand check failed; held with result until next accepted start
- cycles  output  32  cycles of the last operation (acceptance-to-done), updated at done

## Operation
- States: IDLE, SQR, MUL, FIN.
- IDLE: on start, capture base, exp, modulus, const_time; R←1, bit index i←WIDTH-1, cleared cycle counter. If modulus<2 or base≥modulus, go to FIN with error; otherwise go to SQR.
- SQR: R←R·R mod n using the modmul. On completion: if const_time=1 or exp[i]=1, go to MUL; otherwise, if i=0, go to FIN, else i←i-1 and go to SQR.
- MUL: compute T=R·base mod n. Commit R←T only if exp[i]=1; the product is discarded when exp[i]=0 (const_time dummy). Then, if i=0, go to FIN; else i←i-1 and go to SQR.
- FIN: done=1 for one cycle; result←R (0 on error); error, cycles updated; go to IDLE.
- All WIDTH exponent bits are scanned; leading zeros are not skipped.
- Modmul (interleaved, MSB-first over multiplier a): P←0. For each of WIDTH bits: P←2P (+b if a bit set), then subtract n at most twice while P≥n. The accumulator is WIDTH+2 bits; operands and output are < n.
- exp=0 gives result 1.
- start while busy is ignored; inputs are not re-sampled.
- rst asserted at any time: all state returns to IDLE and outputs go to reset values immediately. An in-flight operation is lost with no done.

## Timing
- Reset values: result=0, busy=0, done=0, error=0, cycles=0.
- Each modmul takes exactly WIDTH cycles (one bit per cycle).
- Let start be sampled at the end of cycle 0, and let m = WIDTH if const_time=1, else popcount(exp).
  - Computation occupies cycles 1..WIDTH·(WIDTH+m).
  - done, and the updated result/error/cycles, are visible in cycle L = WIDTH·(WIDTH+m)+1.
  - cycles reports L.
- Error path: done=1, error=1, result=0 in cycle 1; cycles=1.
- busy=1 in cycles 1..L. busy=0 in cycle L+1, and start is accepted in that cycle.
- With const_time=1, L = 2·WIDTH²+1 for every exp/base/modulus. Any deviation is a failure.

## Test plan
- WIDTH=8, base=5, exp=3, modulus=33, const_time=0 -> result=26, done in cycle 81, cycles=81, error=0; same with const_time=1 -> result=26, cycles=129.
- base=26, exp=7, modulus=33 (decrypt, d=7) -> result=5; const_time=0 cycles=89; const_time=1 cycles=129.
- exp=0, base=7, modulus=33, const_time=0 -> result=1, cycles=65; base=32, exp=255, modulus=33 -> result=32, cycles=129 in both modes.
- modulus=1 or base=40 with modulus=33 -> done in cycle 1, error=1, result=0; next valid start clears error.
- start pulsed every cycle during an operation -> single done at the expected cycle, result from the first operands; back-to-back start in cycle L+1 accepted.
- rst asserted mid-SQR -> busy/done/result/error/cycles return to 0 at once, no done afterwards; a new operation then completes correctly.
